grant_accumulator: RTL

GRANT_ACCUMULATOR -- requirements
Module: grant_accumulator

---
 rtl/accum_pkg.sv | 15 +
 rtl/lane_select.sv | 29 ++
 rtl/grant_accumulator.sv | 136 +++++++++++++
 3 files changed

// File: rtl/accum_pkg.sv
// Shared defaults and state encoding for the grant accumulator.
package accum_pkg;

  localparam int LANES_DEF  = 4;
  localparam int DATA_W_DEF = 16;
  localparam int SUM_W_DEF  = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/lane_select.sv
// One-hot operand mux with one-hot / multi-hot grant detection (purely combinational).
module lane_select
  import accum_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [LANES-1:0]        i_grant,
  input  logic [LANES*DATA_W-1:0] i_data,
  output logic [DATA_W-1:0]       o_operand,
  output logic                    o_one_hot,
  output logic                    o_multi_hot
);

  logic [7:0] w_cnt;

  // Masked OR of all lanes; only meaningful to the caller when the grant is one-hot.
  always_comb begin
    o_operand = {DATA_W{1'b0}};
    w_cnt     = 8'd0;
    for (int i = 0; i < LANES; i++) begin
      o_operand = o_operand | (i_data[i*DATA_W +: DATA_W] & {DATA_W{i_grant[i]}});
      w_cnt     = w_cnt + {7'd0, i_grant[i]};
    end
    o_one_hot   = (w_cnt == 8'd1);
    o_multi_hot = (w_cnt > 8'd1);
  end

endmodule

// File: rtl/grant_accumulator.sv
// Accumulates operands from one-hot granted lanes through a two-stage pipeline.
// Define GRANT_ACC_SATURATE_EN to clamp the sum on carry instead of wrapping.
module grant_accumulator
  import accum_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SUM_W  = SUM_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES-1:0]        grant,
  input  logic [LANES*DATA_W-1:0] data_in,
  input  logic                    start,
  input  logic [7:0]              count,
  output logic [LANES-1:0]        ack,
  output logic [SUM_W-1:0]        sum,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic                    grant_err
);

  state_t              r_state;
  logic [7:0]          r_remaining;
  logic [DATA_W-1:0]   r_stage1;
  logic                r_stage1_vld;
  logic [SUM_W-1:0]    r_sum;
  logic                r_busy;
  logic                r_done;
  logic                r_overflow;
  logic                r_grant_err;

  logic [DATA_W-1:0]   w_operand;
  logic                w_one_hot;
  logic                w_multi_hot;
  logic                w_accept;
  logic [SUM_W:0]      w_add;
  logic [SUM_W-1:0]    w_sum_next;

  lane_select #(
    .LANES  (LANES),
    .DATA_W (DATA_W)
  ) u_lane_select (
    .i_grant     (grant),
    .i_data      (data_in),
    .o_operand   (w_operand),
    .o_one_hot   (w_one_hot),
    .o_multi_hot (w_multi_hot)
  );

  // Accept decision and the stage-2 adder with its carry handling.
  always_comb begin
    w_accept = !reset && (r_state == ST_ACCUM) && (r_remaining != 8'd0) && w_one_hot;
    ack      = w_accept ? grant : {LANES{1'b0}};
    w_add    = {1'b0, r_sum} + {{(SUM_W-DATA_W+1){1'b0}}, r_stage1};
`ifdef GRANT_ACC_SATURATE_EN
    w_sum_next = w_add[SUM_W] ? {SUM_W{1'b1}} : w_add[SUM_W-1:0];
`else
    w_sum_next = w_add[SUM_W-1:0];
`endif
  end

  // Control FSM, operand pipeline and sticky status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_remaining  <= 8'd0;
      r_stage1     <= {DATA_W{1'b0}};
      r_stage1_vld <= 1'b0;
      r_sum        <= {SUM_W{1'b0}};
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_grant_err  <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_stage1_vld <= w_accept;
      if (r_stage1_vld) begin
        r_sum <= w_sum_next;
        if (w_add[SUM_W]) begin
          r_overflow <= 1'b1;
        end
      end
      if (w_accept) begin
        r_stage1    <= w_operand;
        r_remaining <= r_remaining - 8'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sum       <= {SUM_W{1'b0}};
            r_overflow  <= 1'b0;
            r_grant_err <= 1'b0;
            r_remaining <= count;
            r_busy      <= 1'b1;
            if (count != 8'd0) begin
              r_state <= ST_ACCUM;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_ACCUM: begin
          if (w_multi_hot) begin
            r_grant_err <= 1'b1;
          end
          if (w_accept && (r_remaining == 8'd1)) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The last operand lands in sum at this edge, so done rises with it.
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sum       = r_sum;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overflow  = r_overflow;
  assign grant_err = r_grant_err;

endmodule
